inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ICACHE_LINES, default 16, number of direct-mapped one-word icache lines (power of two, 2..256).
REQ-002 Parameter RESET_PC, default 32'h0, PC value loaded on reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 rdy  input  1  global enable; 0 freezes all state.
REQ-006 iJP_en  input  1  PC redirect request (branch mispredict/jump) valid.
REQ-007 iJP_pc  input  32  redirect target PC.
REQ-008 iQ_full  input  1  downstream instruction queue full.
REQ-009 oQ_en  output  1  instruction valid to queue, one-cycle pulse per instruction.
REQ-010 oQ_inst  output  32  fetched instruction.
REQ-011 oQ_pc  output  32  PC of oQ_inst.
REQ-012 oMC_en  output  1  instruction-read request to memory controller.
REQ-013 oMC_addr  output  32  request address, word-aligned.
REQ-014 iMC_done  input  1  memory controller read complete, one-cycle pulse.
REQ-015 iMC_inst  input  32  instruction word, valid when iMC_done=1.

Function
REQ-016 Cache index = pc[log2(ICACHE_LINES)+1:2]; tag = remaining upper PC bits; pc[1:0] ignored.
REQ-017 States SHALL be IDLE, MISS, DISCARD.
REQ-018 IDLE, no redirect, hit, iQ_full=0: next edge oQ_en<=1, oQ_inst<=line data, oQ_pc<=pc, pc<=pc+4 (mod 2^32).
REQ-019 IDLE, hit, iQ_full=1: oQ_en<=0, pc unchanged.
REQ-020 IDLE, miss: oMC_en<=1, oMC_addr<=pc, latch miss address, state->MISS, oQ_en<=0.
REQ-021 MISS: oMC_en and oMC_addr held constant until iMC_done.
REQ-022 MISS and iMC_done: write line (valid, tag, data) at latched address, oMC_en<=0, state->IDLE; instruction delivered via the hit path on a later cycle.
REQ-023 Hit-path latency 1 cycle; miss-to-delivery = memctrl latency + 2 cycles.
REQ-024 iJP_en has priority over every other event: pc<=iJP_pc, oQ_en<=0 on that edge, even if iQ_full=1 or a hit is present.
REQ-025 iJP_en in IDLE: state stays IDLE.
REQ-026 iJP_en in MISS without iMC_done: oMC_en<=0, state->DISCARD (memory controller cannot abort an in-flight read).
REQ-027 iJP_en in MISS with iMC_done: line filled, state->IDLE.
REQ-028 DISCARD: oMC_en held 0; on iMC_done write line at latched address, state->IDLE; no instruction delivered.
REQ-029 Further iJP_en in DISCARD updates pc only; state unchanged.
REQ-030 oQ_en SHALL deassert the edge after any pulse unless REQ-018 fires again; at most one instruction per cycle.
REQ-031 iMC_done in IDLE is ignored.
REQ-032 rdy=0: no register changes, including pc, cache, state, outputs; pending iJP_en/iMC_done in that cycle is lost.
REQ-033 oMC_addr SHALL have bits [1:0]=0.

Reset
REQ-034 rst=0 SHALL immediately, asynchronously, set pc=RESET_PC, state=IDLE, all valid bits 0, oQ_en=0, oQ_inst=0, oQ_pc=0, oMC_en=0, oMC_addr=0.
REQ-035 Cache data and tag arrays need not be reset; valid bits gate them.
REQ-036 Reset mid-MISS/DISCARD abandons the request; a later iMC_done is ignored in IDLE.

Verification
REQ-037 Cold start: reset release, memctrl returns 32'h00000013 for addr 0 after 5 cycles -> oMC_en=1 addr 0, then oQ_en=1 inst 32'h00000013 pc 0 two cycles after iMC_done, oMC_en=1 addr 4 next.
REQ-038 Loop hit: lines 0x0..0xC filled, iJP_en to 0x0 -> four consecutive oQ_en pulses, pc 0,4,8,C, no oMC_en.
REQ-039 Backpressure: hit with iQ_full=1 for 3 cycles -> oQ_en=0, pc fixed; iQ_full drops -> delivery next edge.
REQ-040 Redirect mid-miss: miss at 0x100, iJP_en to 0x40 two cycles later -> oMC_en falls, DISCARD; iMC_done fills 0x100 line, no oQ_en; then fetch of 0x40 proceeds.
REQ-041 Conflict: ICACHE_LINES=16, fill 0x0 then fetch 0x40 -> miss, line replaced; return to 0x0 -> miss again.
REQ-042 Async reset asserted mid-MISS with clock stopped -> all outputs 0 immediately; iMC_done after release produces no fill or oQ_en.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit with a direct-mapped, one-word-per-line instruction cache.
// Misses go to the memory controller; a redirect can abandon (but not cancel) an in-flight read.
module inst_fetch #(
    parameter int unsigned ICACHE_LINES = 16,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        iJP_en,
    input  logic [31:0] iJP_pc,
    input  logic        iQ_full,
    output logic        oQ_en,
    output logic [31:0] oQ_inst,
    output logic [31:0] oQ_pc,
    output logic        oMC_en,
    output logic [31:0] oMC_addr,
    input  logic        iMC_done,
    input  logic [31:0] iMC_inst
);
    localparam int unsigned IdxW = $clog2(ICACHE_LINES);
    localparam int unsigned TagW = 30 - IdxW;

    typedef enum logic [1:0] {StIdle, StMiss, StDiscard} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic                    q_en_q, q_en_d;
    logic [31:0]             q_inst_q, q_inst_d;
    logic [31:0]             q_pc_q, q_pc_d;
    logic                    mc_en_q, mc_en_d;
    logic [31:0]             mc_addr_q, mc_addr_d;
    logic [ICACHE_LINES-1:0] valid_q, valid_d;
    logic [TagW-1:0]         tag_q [ICACHE_LINES];
    logic [31:0]             data_q [ICACHE_LINES];

    logic [IdxW-1:0] pc_idx, fill_idx;
    logic [TagW-1:0] pc_tag, fill_tag;
    logic            hit;
    logic            fill_en;

    assign pc_idx   = pc_q[IdxW+1:2];
    assign pc_tag   = pc_q[31:IdxW+2];
    // mc_addr_q doubles as the latched miss address; it stays put across a redirect
    assign fill_idx = mc_addr_q[IdxW+1:2];
    assign fill_tag = mc_addr_q[31:IdxW+2];
    assign hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        q_en_d    = q_en_q;
        q_inst_d  = q_inst_q;
        q_pc_d    = q_pc_q;
        mc_en_d   = mc_en_q;
        mc_addr_d = mc_addr_q;
        valid_d   = valid_q;
        fill_en   = 1'b0;
        if (rdy) begin
            q_en_d = 1'b0;
            if (iJP_en) begin
                pc_d = iJP_pc;
            end
            unique case (state_q)
                StIdle: begin
                    if (!iJP_en) begin
                        if (hit) begin
                            if (!iQ_full) begin
                                q_en_d   = 1'b1;
                                q_inst_d = data_q[pc_idx];
                                q_pc_d   = pc_q;
                                pc_d     = pc_q + 32'd4;
                            end
                        end else begin
                            mc_en_d   = 1'b1;
                            mc_addr_d = {pc_q[31:2], 2'b00};
                            state_d   = StMiss;
                        end
                    end
                end
                StMiss: begin
                    if (iMC_done) begin
                        fill_en = 1'b1;
                        mc_en_d = 1'b0;
                        state_d = StIdle;
                    end else if (iJP_en) begin
                        mc_en_d = 1'b0;
                        state_d = StDiscard;
                    end
                end
                StDiscard: begin
                    if (iMC_done) begin
                        fill_en = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (fill_en) begin
                valid_d[fill_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            q_en_q    <= 1'b0;
            q_inst_q  <= 32'h0;
            q_pc_q    <= 32'h0;
            mc_en_q   <= 1'b0;
            mc_addr_q <= 32'h0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            q_en_q    <= q_en_d;
            q_inst_q  <= q_inst_d;
            q_pc_q    <= q_pc_d;
            mc_en_q   <= mc_en_d;
            mc_addr_q <= mc_addr_d;
            valid_q   <= valid_d;
        end
    end

    // Tag and data arrays are qualified by valid_q, so they carry no reset
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iMC_inst;
        end
    end

    assign oQ_en    = q_en_q;
    assign oQ_inst  = q_inst_q;
    assign oQ_pc    = q_pc_q;
    assign oMC_en   = mc_en_q;
    assign oMC_addr = mc_addr_q;

endmodule
